// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multi-port ID-stage register file:
//   sweep FSM state encoding, default depth and the hardwired zero register.
//   The optional debug read port is controlled by REGFILE_DEBUG_PORT_EN
//   (see register_file_mp).
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_t;

  localparam int unsigned NB_ADDR_DEF = 5;
  localparam int unsigned DEPTH       = 2 ** NB_ADDR_DEF;
  localparam int unsigned ZERO_REG    = 0;

  // Depth for an arbitrary address width (modules parametrise NB_ADDR).
  function automatic int unsigned regfile_depth(input int unsigned nb_addr);
    return 32'd1 << nb_addr;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   One pending-write bit per register. Decode claims a destination (set),
//   WB retires it (clear); a same-cycle claim and write to one register
//   leaves it busy because the new producer supersedes the retiring one.
//   Register 0 is never marked busy.
//
// Ports
//   i_clk, i_reset_n  clock, async active-low reset (clears all bits)
//   i_enable          block is READY; claims/writes ignored otherwise
//   i_wr_en/addr      WB write (clears busy bit)
//   i_claim_en/addr   decode claim (sets busy bit)
//   i_rd_addr         packed read addresses, N_RD ports
//   o_rd_busy         per-port busy, masked when the WB write bypasses
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int N_RD    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic                     i_wr_en,
  input  logic [NB_ADDR-1:0]       i_wr_addr,
  input  logic                     i_claim_en,
  input  logic [NB_ADDR-1:0]       i_claim_addr,
  input  logic [N_RD*NB_ADDR-1:0]  i_rd_addr,
  output logic [N_RD-1:0]          o_rd_busy
);

  localparam int unsigned         RF_DEPTH = regfile_depth(NB_ADDR);
  localparam logic [NB_ADDR-1:0]  ZA       = NB_ADDR'(ZERO_REG);

  logic [RF_DEPTH-1:0] busy;

  // The claim assignment is placed after the clear so it wins on a collision.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy <= '0;
    end else if (i_enable) begin
      if (i_wr_en && (i_wr_addr != ZA)) busy[i_wr_addr] <= 1'b0;
      if (i_claim_en && (i_claim_addr != ZA)) busy[i_claim_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_busy
    logic [NB_ADDR-1:0] rd_addr;
    assign rd_addr = i_rd_addr[k*NB_ADDR +: NB_ADDR];
    // A write landing this cycle is forwarded by the bypass, so no stall.
    assign o_rd_busy[k] = i_enable & busy[rd_addr] &
                          ~(i_wr_en & (i_wr_addr == rd_addr));
  end

endmodule

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//   ID-stage register file with N_RD combinational read ports, same-cycle
//   WB-to-read bypass, hardwired zero register, pending-write scoreboard and
//   a post-reset clear sweep that zeroes the array one entry per cycle.
//
// Ports
//   i_clk, i_reset_n  clock, async active-low reset
//   i_wr_en/addr/data WB write port (ignored during the clear sweep)
//   i_rd_addr         packed read addresses, port k at [k*NB_ADDR +: NB_ADDR]
//   o_rd_data         packed read data, same packing
//   o_rd_busy         per-port pending-write flag
//   i_claim_en/addr   decode destination claim
//   o_ready           clear sweep finished (registered)
//
// Optional: `define REGFILE_DEBUG_PORT_EN adds i_dbg_addr / o_dbg_data, a
//   registered (one-cycle, non-bypassed) read port for the UART debug unit.
// ---------------------------------------------------------------------------
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int N_RD    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_wr_en,
  input  logic [NB_ADDR-1:0]       i_wr_addr,
  input  logic [NB_REG-1:0]        i_wr_data,
  input  logic [N_RD*NB_ADDR-1:0]  i_rd_addr,
  output logic [N_RD*NB_REG-1:0]   o_rd_data,
  output logic [N_RD-1:0]          o_rd_busy,
  input  logic                     i_claim_en,
  input  logic [NB_ADDR-1:0]       i_claim_addr,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [NB_ADDR-1:0]       i_dbg_addr,
  output logic [NB_REG-1:0]        o_dbg_data,
`endif
  output logic                     o_ready
);

  localparam int unsigned         RF_DEPTH   = regfile_depth(NB_ADDR);
  localparam logic [NB_ADDR-1:0]  ZA         = NB_ADDR'(ZERO_REG);
  localparam logic [NB_ADDR:0]    SWEEP_LAST = (NB_ADDR+1)'(RF_DEPTH - 1);

  rf_state_t          state;
  logic [NB_ADDR:0]   sweep_cnt;
  logic               ready;
  logic [NB_REG-1:0]  mem [RF_DEPTH];

  assign ready = (state == ST_READY);

  // Sweep FSM: one array entry cleared per cycle, then READY until reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
      o_ready   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == SWEEP_LAST) begin
            state   <= ST_READY;
            o_ready <= 1'b1;
          end
        end
        ST_READY: begin
          state   <= ST_READY;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= ST_CLEAR;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; the sweep provides the known-zero contents.
  always_ff @(posedge i_clk) begin
    if (!ready) begin
      mem[sweep_cnt[NB_ADDR-1:0]] <= '0;
    end else if (i_wr_en && (i_wr_addr != ZA)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [NB_ADDR-1:0] rd_addr;
    logic [NB_REG-1:0]  rd_data;
    assign rd_addr = i_rd_addr[k*NB_ADDR +: NB_ADDR];
    always_comb begin
      rd_data = '0;
      if (ready && (rd_addr != ZA)) begin
        if (i_wr_en && (i_wr_addr == rd_addr)) rd_data = i_wr_data;
        else                                   rd_data = mem[rd_addr];
      end
    end
    assign o_rd_data[k*NB_REG +: NB_REG] = rd_data;
  end

  regfile_scoreboard #(
    .NB_ADDR (NB_ADDR),
    .N_RD    (N_RD)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (ready),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_claim_en   (i_claim_en),
    .i_claim_addr (i_claim_addr),
    .i_rd_addr    (i_rd_addr),
    .o_rd_busy    (o_rd_busy)
  );

`ifdef REGFILE_DEBUG_PORT_EN
  // Registered debug read; deliberately not bypassed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dbg_data <= '0;
    end else if (!ready || (i_dbg_addr == ZA)) begin
      o_dbg_data <= '0;
    end else begin
      o_dbg_data <= mem[i_dbg_addr];
    end
  end
`endif

endmodule
